// File: rtl/cpu_core_mc_if.sv
// Instruction/data memory bus of the multi-cycle core; master = core, slave = memories.
// Handshake: a request is live while *_req=1; addr/we/wdata hold until the cycle with *_ready=1
// completes it, and ready is ignored whenever req=0.
interface cpu_core_mc_if #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int IMEM_W  = 8,
  parameter int DMEM_AW = 4
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [IMEM_W-1:0] imem_rdata;
  logic              imem_ready;

  logic               dmem_req;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: fetch / immediate / execute / memory FSM over req-ready memories,
// with zero and carry flags, branches and a terminal HALT state.
module cpu_core_mc #(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 8,
  parameter int NUM_REGS = 4,
  parameter int IMEM_W   = 8,
  parameter int DMEM_AW  = 4
) (
  input  logic              clk,
  input  logic              reset,
  cpu_core_mc_if.master     bus,
  output logic [DATA_W-1:0] alu_result,
  output logic              instr_done,
  output logic              halted,
  output logic [2:0]        state_dbg,
  output logic              flag_z,
  output logic              flag_c
);
  localparam int RS_W = $clog2(NUM_REGS);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BEQZ = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SHR  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_IMM   = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [IMEM_W-1:0] ir;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [3:0]        op;
  logic [RS_W-1:0]   rd_idx;
  logic [RS_W-1:0]   rs_idx;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;

  assign op     = ir[IMEM_W-1 -: 4];
  assign rd_idx = ir[RS_W*2-1 : RS_W];
  assign rs_idx = ir[RS_W-1:0];
  assign rd_val = regs[rd_idx];
  assign rs_val = regs[rs_idx];

  function automatic logic is_two_word(input logic [3:0] o);
    return o inside {OP_LDI, OP_ADDI, OP_JMP, OP_BEQZ};
  endfunction

  // Execute-stage result; wr_en marks ops that write rd, c_upd marks ops that own the carry.
  logic [DATA_W:0]   wide;
  logic [DATA_W-1:0] res;
  logic              res_c;
  logic              wr_en;
  logic              c_upd;

  always_comb begin
    wide  = '0;
    res   = '0;
    res_c = 1'b0;
    wr_en = 1'b0;
    c_upd = 1'b0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, rd_val} + {1'b0, rs_val};
        res   = wide[DATA_W-1:0];
        res_c = wide[DATA_W];
        wr_en = 1'b1;
        c_upd = 1'b1;
      end
      OP_SUB: begin
        res   = rd_val - rs_val;
        res_c = (rd_val < rs_val);
        wr_en = 1'b1;
        c_upd = 1'b1;
      end
      OP_AND: begin
        res   = rd_val & rs_val;
        wr_en = 1'b1;
        c_upd = 1'b1;
      end
      OP_OR: begin
        res   = rd_val | rs_val;
        wr_en = 1'b1;
        c_upd = 1'b1;
      end
      OP_XOR: begin
        res   = rd_val ^ rs_val;
        wr_en = 1'b1;
        c_upd = 1'b1;
      end
      OP_MOV: begin
        res   = rs_val;
        wr_en = 1'b1;
      end
      OP_LDI: begin
        res   = imm;
        wr_en = 1'b1;
      end
      OP_ADDI: begin
        wide  = {1'b0, rd_val} + {1'b0, imm};
        res   = wide[DATA_W-1:0];
        res_c = wide[DATA_W];
        wr_en = 1'b1;
        c_upd = 1'b1;
      end
      OP_SHL: begin
        res   = rd_val << 1;
        res_c = rd_val[DATA_W-1];
        wr_en = 1'b1;
        c_upd = 1'b1;
      end
      OP_SHR: begin
        res   = rd_val >> 1;
        res_c = rd_val[0];
        wr_en = 1'b1;
        c_upd = 1'b1;
      end
      default: begin
        res = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      imm        <= '0;
      alu_result <= '0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      instr_done <= 1'b0;
      case (state)
        S_FETCH: begin
          if (bus.imem_ready) begin
            ir    <= bus.imem_rdata;
            pc    <= pc + PC_W'(1);
            state <= is_two_word(bus.imem_rdata[IMEM_W-1 -: 4]) ? S_IMM : S_EXEC;
          end
        end
        S_IMM: begin
          if (bus.imem_ready) begin
            imm   <= DATA_W'(bus.imem_rdata);
            pc    <= pc + PC_W'(1);
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state      <= S_FETCH;
          instr_done <= 1'b1;
          if (wr_en) begin
            regs[rd_idx] <= res;
            alu_result   <= res;
            flag_z       <= (res == '0);
            if (c_upd) begin
              flag_c <= res_c;
            end
          end
          case (op)
            OP_LD, OP_ST: begin
              state      <= S_MEM;
              instr_done <= 1'b0;
            end
            OP_JMP: pc <= PC_W'(imm);
            OP_BEQZ: begin
              if (rd_val == '0) begin
                pc <= PC_W'(imm);
              end
            end
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: begin
              state <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            if (op == OP_LD) begin
              regs[rd_idx] <= bus.dmem_rdata;
              alu_result   <= bus.dmem_rdata;
              flag_z       <= (bus.dmem_rdata == '0);
            end
            instr_done <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  // Bus outputs decode straight from registered state so they are stable for the whole wait.
  assign bus.imem_req   = (state == S_FETCH) || (state == S_IMM);
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (state == S_MEM);
  assign bus.dmem_we    = (state == S_MEM) && (op == OP_ST);
  assign bus.dmem_addr  = (state == S_MEM) ? rs_val[DMEM_AW-1:0] : '0;
  assign bus.dmem_wdata = ((state == S_MEM) && (op == OP_ST)) ? rd_val : '0;
  assign state_dbg      = state;
endmodule

// File: tb/tb_cpu_core_mc.sv
// Bench for cpu_core_mc: wait-state memory responder, directed scenarios and a random
// program checked against an instruction-level reference model.
module tb_cpu_core_mc;
  localparam int DATA_W   = 8;
  localparam int PC_W     = 8;
  localparam int NUM_REGS = 4;
  localparam int IMEM_W   = 8;
  localparam int DMEM_AW  = 4;
  localparam int REC_W    = PC_W + DATA_W + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_core_mc_if #(.DATA_W(DATA_W), .PC_W(PC_W), .IMEM_W(IMEM_W), .DMEM_AW(DMEM_AW)) bus ();

  logic [DATA_W-1:0] alu_result;
  logic              instr_done;
  logic              halted;
  logic [2:0]        state_dbg;
  logic              flag_z;
  logic              flag_c;

  cpu_core_mc #(
    .DATA_W(DATA_W), .PC_W(PC_W), .NUM_REGS(NUM_REGS), .IMEM_W(IMEM_W), .DMEM_AW(DMEM_AW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .alu_result(alu_result), .instr_done(instr_done),
    .halted(halted), .state_dbg(state_dbg), .flag_z(flag_z), .flag_c(flag_c)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [REC_W-1:0] exp_q[$];

  logic [7:0] imem [256];
  logic [7:0] dmem [16];
  int imem_wait_lo = 0, imem_wait_hi = 0, dmem_wait_lo = 0, dmem_wait_hi = 0;
  int imem_xfers = 0, dmem_xfers = 0, stall_violations = 0;

  // Memory responder state
  bit r_seen, i_pend, d_pend, i_stall, d_stall;
  int i_left, d_left;
  logic [PC_W-1:0] i_hold;
  logic [DMEM_AW+DATA_W:0] d_hold;

  initial begin : mem_responder
    bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;
    i_pend = 0; d_pend = 0; i_stall = 0; d_stall = 0; i_left = 0; d_left = 0;
    forever begin
      @(posedge clk);
      r_seen = reset;
      if (!r_seen && bus.imem_req && bus.imem_ready) imem_xfers++;
      if (!r_seen && bus.dmem_req && bus.dmem_ready) begin
        dmem_xfers++;
        if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
      end
      @(negedge clk);
      if (r_seen) begin
        i_pend = 0; d_pend = 0; i_stall = 0; d_stall = 0;
      end
      if (i_stall && (!bus.imem_req || bus.imem_addr !== i_hold)) stall_violations++;
      if (d_stall && (!bus.dmem_req || {bus.dmem_addr, bus.dmem_we, bus.dmem_wdata} !== d_hold))
        stall_violations++;
      if (bus.imem_req) begin
        if (!i_pend) begin
          i_pend = 1;
          i_left = $urandom_range(imem_wait_hi, imem_wait_lo);
        end
        bus.imem_rdata = imem[bus.imem_addr];
        if (i_left == 0) begin
          bus.imem_ready = 1'b1; i_pend = 0; i_stall = 0;
        end else begin
          bus.imem_ready = 1'b0; i_left--; i_stall = 1; i_hold = bus.imem_addr;
        end
      end else begin
        bus.imem_ready = 1'b0; i_pend = 0; i_stall = 0;
      end
      if (bus.dmem_req) begin
        if (!d_pend) begin
          d_pend = 1;
          d_left = $urandom_range(dmem_wait_hi, dmem_wait_lo);
        end
        bus.dmem_rdata = dmem[bus.dmem_addr];
        if (d_left == 0) begin
          bus.dmem_ready = 1'b1; d_pend = 0; d_stall = 0;
        end else begin
          bus.dmem_ready = 1'b0; d_left--; d_stall = 1;
          d_hold = {bus.dmem_addr, bus.dmem_we, bus.dmem_wdata};
        end
      end else begin
        bus.dmem_ready = 1'b0; d_pend = 0; d_stall = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] enc(input int op, input int rd, input int rs);
    return 8'((op << 4) | (rd << 2) | rs);
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 8'hF0;
  endtask

  task automatic set_waits(input int ilo, input int ihi, input int dlo, input int dhi);
    imem_wait_lo = ilo; imem_wait_hi = ihi; dmem_wait_lo = dlo; dmem_wait_hi = dhi;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    imem_xfers = 0; dmem_xfers = 0; stall_violations = 0;
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (instr_done) begin
        ok = 1;
        return;
      end
    end
  endtask

  // Latency from the first fetch of `target` to the n-th retirement pulse.
  task automatic run_trace(input int target, input int n_done, input int budget,
                           output int lat, output bit ok);
    int t, t_start, dones;
    t = 0; t_start = -1; dones = 0; lat = -1; ok = 0;
    forever begin
      if (t_start < 0 && bus.imem_req && bus.imem_addr == PC_W'(target)) t_start = t;
      if (instr_done) dones++;
      if (dones >= n_done || t >= budget) break;
      @(negedge clk);
      t++;
    end
    if (dones >= n_done && t_start >= 0) begin
      ok = 1;
      lat = t - t_start;
    end
  endtask

  task automatic test_reset();
    clear_imem();
    set_waits(0, 0, 0, 0);
    apply_reset();
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL reset_imem_req: got %0b expected 1", bus.imem_req); else n_pass++;
    n_total++; if (bus.imem_addr !== 8'h00) $display("FAIL reset_imem_addr: got %0h expected 0", bus.imem_addr); else n_pass++;
    n_total++; if (bus.dmem_req !== 1'b0) $display("FAIL reset_dmem_req: got %0b expected 0", bus.dmem_req); else n_pass++;
    n_total++; if (alu_result !== 8'h00) $display("FAIL reset_alu: got %0h expected 0", alu_result); else n_pass++;
    n_total++; if ({instr_done, halted, flag_z, flag_c} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {instr_done, halted, flag_z, flag_c}); else n_pass++;
  endtask

  task automatic test_add();
    int lat; bit ok;
    clear_imem();
    imem[0] = enc(7, 0, 0); imem[1] = 8'd3;
    imem[2] = enc(7, 1, 0); imem[3] = 8'd5;
    imem[4] = enc(1, 0, 1);
    set_waits(0, 0, 0, 0);
    apply_reset();
    run_trace(4, 3, 60, lat, ok);
    n_total++; if (!ok || lat != 2) $display("FAIL add_latency: got %0d (ok=%0b) expected 2", lat, ok); else n_pass++;
    n_total++; if (alu_result !== 8'd8) $display("FAIL add_result: got %0h expected 8", alu_result); else n_pass++;
    n_total++; if ({flag_z, flag_c} !== 2'b00) $display("FAIL add_flags: got %b expected 00", {flag_z, flag_c}); else n_pass++;
    wait_done(20, ok);
    n_total++; if (!ok || halted !== 1'b1) $display("FAIL add_halt: got halted=%0b ok=%0b expected 1", halted, ok); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [9:0] exp_tab [9];
    bit ok;
    clear_imem();
    imem[0] = enc(7, 0, 0);  imem[1] = 8'hFF;
    imem[2] = enc(8, 0, 0);  imem[3] = 8'h01;
    imem[4] = enc(7, 1, 0);  imem[5] = 8'h01;
    imem[6] = enc(2, 0, 1);
    imem[7] = enc(5, 1, 1);
    imem[8] = enc(7, 3, 0);  imem[9] = 8'h81;
    imem[10] = enc(13, 3, 0);
    imem[11] = enc(14, 3, 0);
    // {alu_result, Z, C} after each retirement; the last entry is HALT
    exp_tab = '{{8'hFF, 2'b00}, {8'h00, 2'b11}, {8'h01, 2'b01}, {8'hFF, 2'b01}, {8'h00, 2'b10},
                {8'h81, 2'b00}, {8'h02, 2'b01}, {8'h01, 2'b00}, {8'h01, 2'b00}};
    set_waits(0, 1, 0, 0);
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      wait_done(40, ok);
      n_total++;
      if (!ok || {alu_result, flag_z, flag_c} !== exp_tab[i])
        $display("FAIL overflow_step%0d: got alu=%0h z=%0b c=%0b ok=%0b expected %0h/%b", i,
                 alu_result, flag_z, flag_c, ok, exp_tab[i][9:2], exp_tab[i][1:0]);
      else n_pass++;
    end
    n_total++; if (halted !== 1'b1) $display("FAIL overflow_halt: got %0b expected 1", halted); else n_pass++;
  endtask

  task automatic test_wait_states();
    int lat; bit ok;
    clear_imem();
    imem[0] = enc(7, 2, 0); imem[1] = 8'h5A;
    set_waits(3, 3, 0, 0);
    apply_reset();
    run_trace(0, 1, 80, lat, ok);
    n_total++; if (!ok || lat != 9) $display("FAIL wait_ldi_latency: got %0d (ok=%0b) expected 9", lat, ok); else n_pass++;
    n_total++; if (imem_xfers != 2) $display("FAIL wait_fetch_count: got %0d expected 2", imem_xfers); else n_pass++;
    n_total++; if (alu_result !== 8'h5A) $display("FAIL wait_ldi_result: got %0h expected 5a", alu_result); else n_pass++;
    n_total++; if (stall_violations != 0) $display("FAIL wait_imem_stable: got %0d violations expected 0", stall_violations); else n_pass++;

    clear_imem();
    imem[0] = enc(7, 1, 0); imem[1] = 8'h03;
    imem[2] = enc(9, 0, 1);
    dmem[3] = 8'hC3;
    set_waits(0, 0, 2, 2);
    apply_reset();
    run_trace(2, 2, 80, lat, ok);
    n_total++; if (!ok || lat != 5) $display("FAIL wait_ld_latency: got %0d (ok=%0b) expected 5", lat, ok); else n_pass++;
    n_total++; if (alu_result !== 8'hC3) $display("FAIL wait_ld_result: got %0h expected c3", alu_result); else n_pass++;
    n_total++; if (dmem_xfers != 1) $display("FAIL wait_ld_count: got %0d expected 1", dmem_xfers); else n_pass++;
    n_total++; if (stall_violations != 0) $display("FAIL wait_dmem_stable: got %0d violations expected 0", stall_violations); else n_pass++;
  endtask

  task automatic test_branch();
    bit ok1, ok2, ok3;
    clear_imem();
    imem[0] = enc(7, 2, 0);  imem[1] = 8'h00;
    imem[2] = enc(12, 2, 0); imem[3] = 8'h10;
    imem[4] = enc(0, 0, 0);
    set_waits(0, 0, 0, 0);
    apply_reset();
    wait_done(20, ok1); wait_done(20, ok2);
    n_total++; if (!(ok1 && ok2) || bus.imem_addr !== 8'h10) $display("FAIL beqz_taken: got %0h expected 10", bus.imem_addr); else n_pass++;

    clear_imem();
    imem[0] = enc(7, 2, 0);  imem[1] = 8'h01;
    imem[2] = enc(12, 2, 0); imem[3] = 8'h10;
    imem[16] = enc(0, 0, 0);
    apply_reset();
    wait_done(20, ok1); wait_done(20, ok2);
    n_total++; if (!(ok1 && ok2) || bus.imem_addr !== 8'h04) $display("FAIL beqz_not_taken: got %0h expected 4", bus.imem_addr); else n_pass++;
    wait_done(20, ok3);
    n_total++; if (!ok3 || halted !== 1'b1) $display("FAIL beqz_fallthrough_halt: got %0b expected 1", halted); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    bit ok1, ok2;
    clear_imem();
    imem[0] = enc(11, 0, 0); imem[1] = 8'hFF;
    imem[255] = enc(0, 0, 0);
    set_waits(0, 2, 0, 0);
    apply_reset();
    wait_done(30, ok1);
    n_total++; if (!ok1 || bus.imem_addr !== 8'hFF) $display("FAIL jmp_target: got %0h expected ff", bus.imem_addr); else n_pass++;
    wait_done(30, ok2);
    n_total++; if (!ok2 || bus.imem_addr !== 8'h00) $display("FAIL pc_wrap: got %0h expected 0", bus.imem_addr); else n_pass++;
  endtask

  task automatic test_halt();
    int req_seen, extra_dones;
    bit ok;
    clear_imem();
    set_waits(0, 0, 0, 0);
    apply_reset();
    wait_done(20, ok);
    n_total++; if (!ok || halted !== 1'b1) $display("FAIL halt_flag: got %0b expected 1", halted); else n_pass++;
    req_seen = 0; extra_dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.imem_req) req_seen++;
      if (instr_done) extra_dones++;
    end
    n_total++; if (req_seen != 0) $display("FAIL halt_no_fetch: got %0d requests expected 0", req_seen); else n_pass++;
    n_total++; if (extra_dones != 0) $display("FAIL halt_no_retire: got %0d pulses expected 0", extra_dones); else n_pass++;
  endtask

  task automatic test_random();
    int m_regs [4];
    int m_dmem [16];
    int m_pc, m_z, m_c, m_alu, a, b, imm, r, op, rd, rs;
    bit wr, ok;
    logic [7:0] w;
    logic [REC_W-1:0] got, exp;
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom);
      if (w[7:4] == 4'hF) w[7:4] = 4'h0;
      imem[i] = w;
    end
    for (int i = 0; i < 16; i++) begin
      dmem[i] = 8'($urandom);
      m_dmem[i] = dmem[i];
    end
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_pc = 0; m_z = 0; m_c = 0; m_alu = 0;
    exp_q.delete();
    for (int n = 0; n < 150; n++) begin
      w = imem[m_pc]; m_pc = (m_pc + 1) % 256;
      op = w / 16; rd = (w / 4) % 4; rs = w % 4;
      a = m_regs[rd]; b = m_regs[rs]; imm = 0; r = 0; wr = 1;
      if (op == 7 || op == 8 || op == 11 || op == 12) begin
        imm = imem[m_pc]; m_pc = (m_pc + 1) % 256;
      end
      case (op)
        1: begin r = (a + b) % 256; m_c = (a + b > 255); end
        2: begin r = (a - b + 256) % 256; m_c = (a < b); end
        3: begin r = a & b; m_c = 0; end
        4: begin r = a | b; m_c = 0; end
        5: begin r = a ^ b; m_c = 0; end
        6: r = b;
        7: r = imm;
        8: begin r = (a + imm) % 256; m_c = (a + imm > 255); end
        9: r = m_dmem[b % 16];
        10: begin m_dmem[b % 16] = a; wr = 0; end
        11: begin m_pc = imm; wr = 0; end
        12: begin if (a == 0) m_pc = imm; wr = 0; end
        13: begin m_c = a / 128; r = (a * 2) % 256; end
        14: begin m_c = a % 2; r = a / 2; end
        default: wr = 0;
      endcase
      if (wr) begin
        m_regs[rd] = r; m_z = (r == 0); m_alu = r;
      end
      exp_q.push_back({8'(m_pc), 8'(m_alu), 1'(m_z), 1'(m_c)});
    end
    set_waits(0, 2, 0, 2);
    apply_reset();
    for (int n = 0; n < 150; n++) begin
      wait_done(40, ok);
      n_total++;
      if (!ok) begin
        $display("FAIL random_timeout: retirement %0d not seen within budget", n);
        break;
      end
      got = {bus.imem_addr, alu_result, flag_z, flag_c};
      exp = exp_q.pop_front();
      if (got !== exp) $display("FAIL random_retire%0d: got pc=%0h alu=%0h zc=%b expected pc=%0h alu=%0h zc=%b",
                                n, got[17:10], got[9:2], got[1:0], exp[17:10], exp[9:2], exp[1:0]);
      else n_pass++;
    end
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (dmem[i] !== 8'(m_dmem[i])) $display("FAIL random_dmem%0d: got %0h expected %0h", i, dmem[i], m_dmem[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_mem();
    bit ok, seen;
    clear_imem();
    imem[0] = enc(7, 0, 0); imem[1] = 8'h77;
    imem[2] = enc(7, 1, 0); imem[3] = 8'h05;
    imem[4] = enc(9, 2, 1);
    set_waits(0, 0, 10, 10);
    apply_reset();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.dmem_req) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    n_total++; if (!seen || alu_result !== 8'h05) $display("FAIL mid_mem_pre: got alu=%0h seen=%0b expected 5", alu_result, seen); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++; if (bus.dmem_req !== 1'b0) $display("FAIL mid_mem_req_drop: got %0b expected 0", bus.dmem_req); else n_pass++;
    n_total++; if (alu_result !== 8'h00 || bus.imem_addr !== 8'h00)
      $display("FAIL mid_mem_cleared: got alu=%0h pc=%0h expected 0/0", alu_result, bus.imem_addr); else n_pass++;
    clear_imem();
    imem[0] = enc(1, 0, 1); imem[1] = enc(1, 0, 2); imem[2] = enc(1, 0, 3);
    set_waits(0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      wait_done(20, ok);
      if (!ok) break;
    end
    n_total++; if (!ok || {alu_result, flag_z, flag_c} !== {8'h00, 2'b10})
      $display("FAIL mid_mem_regs_zero: got alu=%0h z=%0b c=%0b expected 0/1/0", alu_result, flag_z, flag_c); else n_pass++;
    wait_done(20, ok);
    n_total++; if (!ok || halted !== 1'b1) $display("FAIL mid_mem_restart_halt: got %0b expected 1", halted); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_wait_states();
    test_branch();
    test_pc_wrap();
    test_halt();
    test_random();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
